// File: rtl/pong_game_ctrl_pkg.sv
// Shared types and constants for the Pong game sequencer.
// Holds the FSM state encoding, datapath widths, default screen-geometry goal
// lines and a saturating score increment helper.
package pong_game_ctrl_pkg;

  localparam int unsigned Y_W     = 6;
  localparam int unsigned DY_W    = 3;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned DIV_W   = 4;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned HIT_W   = 4;
  localparam int unsigned STATE_W = 3;

  // Goal lines in ballY coordinates, shared with ball_move
  localparam int unsigned GOAL_TOP_DEF = 1;
  localparam int unsigned GOAL_BOT_DEF = 62;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  // Score increment that holds at the maximum representable value
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/pong_game_ctrl_tick_divider.sv
// Frame-tick divider for ball motion.
// Ports: clk, rst_n (async active-low), load (cur_div <= div_in, div_cnt <= 0),
//        div_in[3:0], dec (cur_div--, saturating at MIN_DIV), en (count enable),
//        tick_in (frame tick), tick_out (combinational: tick_in that completes a period).
module pong_game_ctrl_tick_divider
  import pong_game_ctrl_pkg::*;
#(
  parameter int unsigned START_DIV = 4,
  parameter int unsigned MIN_DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div_in,
  input  logic             dec,
  input  logic             en,
  input  logic             tick_in,
  output logic             tick_out
);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] cur_div;
  logic             wrap;

  // >= rather than == so a divider that shrinks mid-period never lets div_cnt run away
  assign wrap     = (div_cnt >= (cur_div - DIV_W'(1)));
  assign tick_out = en & tick_in & wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      cur_div <= DIV_W'(START_DIV);
    end else if (load) begin
      div_cnt <= '0;
      cur_div <= div_in;
    end else begin
      if (dec && (cur_div > DIV_W'(MIN_DIV))) begin
        cur_div <= cur_div - DIV_W'(1);
      end
      if (en && tick_in) begin
        div_cnt <= wrap ? '0 : div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: gates ball motion, serves, detects goals, keeps score.
// Ports: clk, rst_n (async active-low), frame_tick (per-frame pulse),
//        start_btn (start pulse), ballY[5:0], ball_dy[2:0] (signed dy),
//        move_tick / ball_rst (one-cycle strobes), score_top/score_bot[3:0],
//        game_over, winner_top, state[2:0]. All outputs registered.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int unsigned START_DIV    = 4,
  parameter int unsigned MIN_DIV      = 1,
  parameter int unsigned RALLY_STEP   = 4,
  parameter int unsigned SERVE_FRAMES = 30,
  parameter int unsigned POINT_FRAMES = 45,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned GOAL_TOP     = GOAL_TOP_DEF,
  parameter int unsigned GOAL_BOT     = GOAL_BOT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic [Y_W-1:0]     ballY,
  input  logic [DY_W-1:0]    ball_dy,
  output logic               move_tick,
  output logic               ball_rst,
  output logic [SCORE_W-1:0] score_top,
  output logic [SCORE_W-1:0] score_bot,
  output logic               game_over,
  output logic               winner_top,
  output logic [STATE_W-1:0] state
);

  state_e           state_q;
  logic [CNT_W-1:0] frame_cnt;
  logic [HIT_W-1:0] hit_cnt;
  logic             dy_sign_q;
  logic             in_play;
  logic             goal_top;
  logic             goal_bot;
  logic             bounce;
  logic             dec;
  logic             tick;
  logic             dy_unused;
  logic             win_reached;

  assign in_play     = (state_q == ST_PLAY);
  assign goal_top    = in_play && (ballY >= Y_W'(GOAL_BOT));  // top player scores
  assign goal_bot    = in_play && (ballY <= Y_W'(GOAL_TOP));  // bottom player scores
  assign bounce      = in_play && (ball_dy[DY_W-1] != dy_sign_q);
  assign dec         = bounce && (hit_cnt == HIT_W'(RALLY_STEP - 1));
  assign win_reached = (score_top == SCORE_W'(WIN_SCORE)) || (score_bot == SCORE_W'(WIN_SCORE));
  assign state       = state_q;
  // Only the direction sign of dy matters for bounce detection
  assign dy_unused   = |ball_dy[DY_W-2:0];

  // ball_rst is high exactly on the SERVE entry cycle, so it doubles as the divider reload
  pong_game_ctrl_tick_divider #(
    .START_DIV (START_DIV),
    .MIN_DIV   (MIN_DIV)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ball_rst),
    .div_in   (DIV_W'(START_DIV)),
    .dec      (dec),
    .en       (in_play),
    .tick_in  (frame_tick),
    .tick_out (tick)
  );

  // Game FSM with counters, scores and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      frame_cnt  <= '0;
      hit_cnt    <= '0;
      dy_sign_q  <= 1'b0;
      score_top  <= '0;
      score_bot  <= '0;
      move_tick  <= 1'b0;
      ball_rst   <= 1'b0;
      game_over  <= 1'b0;
      winner_top <= 1'b0;
    end else begin
      move_tick <= 1'b0;
      ball_rst  <= 1'b0;
      case (state_q)
        ST_IDLE, ST_GAME_OVER: begin
          if (start_btn) begin
            state_q    <= ST_SERVE;
            score_top  <= '0;
            score_bot  <= '0;
            frame_cnt  <= '0;
            hit_cnt    <= '0;
            ball_rst   <= 1'b1;
            game_over  <= 1'b0;
            winner_top <= 1'b0;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            if (frame_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
              state_q   <= ST_PLAY;
              frame_cnt <= '0;
              dy_sign_q <= ball_dy[DY_W-1];
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end
        ST_PLAY: begin
          if (bounce) begin
            dy_sign_q <= ball_dy[DY_W-1];
            hit_cnt   <= dec ? '0 : hit_cnt + HIT_W'(1);
          end
          // A goal suppresses any coincident move strobe
          if (goal_top) begin
            score_top <= sat_inc(score_top);
            state_q   <= ST_POINT;
            frame_cnt <= '0;
          end else if (goal_bot) begin
            score_bot <= sat_inc(score_bot);
            state_q   <= ST_POINT;
            frame_cnt <= '0;
          end else begin
            move_tick <= tick;
          end
        end
        ST_POINT: begin
          if (frame_tick) begin
            if (frame_cnt == CNT_W'(POINT_FRAMES - 1)) begin
              frame_cnt <= '0;
              if (win_reached) begin
                state_q    <= ST_GAME_OVER;
                game_over  <= 1'b1;
                winner_top <= (score_top == SCORE_W'(WIN_SCORE));
              end else begin
                state_q  <= ST_SERVE;
                ball_rst <= 1'b1;
                hit_cnt  <= '0;
              end
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed game scenarios followed by
// random play, all compared cycle by cycle against a rule-level game model.
module tb_pong_game_ctrl;

  localparam int START_DIV    = 4;
  localparam int MIN_DIV      = 1;
  localparam int RALLY_STEP   = 4;
  localparam int SERVE_FRAMES = 30;
  localparam int POINT_FRAMES = 45;
  localparam int WIN_SCORE    = 7;
  localparam int GOAL_TOP     = 1;
  localparam int GOAL_BOT     = 62;

  localparam int P_IDLE  = 0;
  localparam int P_SERVE = 1;
  localparam int P_PLAY  = 2;
  localparam int P_POINT = 3;
  localparam int P_OVER  = 4;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_btn  = 1'b0;
  logic [5:0] ballY      = 6'd32;
  logic [2:0] ball_dy    = 3'b001;
  logic       move_tick;
  logic       ball_rst;
  logic [3:0] score_top;
  logic [3:0] score_bot;
  logic       game_over;
  logic       winner_top;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  int obs_moves = 0;

  // Rule-level model of the game
  int m_state, m_frames, m_bounces, m_since, m_top, m_bot;
  bit m_sign;
  int e_move, e_rst, e_go, e_win;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .ballY      (ballY),
    .ball_dy    (ball_dy),
    .move_tick  (move_tick),
    .ball_rst   (ball_rst),
    .score_top  (score_top),
    .score_bot  (score_bot),
    .game_over  (game_over),
    .winner_top (winner_top),
    .state      (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state",      32'(state),      32'(m_state));
    chk("move_tick",  32'(move_tick),  32'(e_move));
    chk("ball_rst",   32'(ball_rst),   32'(e_rst));
    chk("score_top",  32'(score_top),  32'(m_top));
    chk("score_bot",  32'(score_bot),  32'(m_bot));
    chk("game_over",  32'(game_over),  32'(e_go));
    chk("winner_top", 32'(winner_top), 32'(e_win));
  endtask

  task automatic model_reset();
    m_state = P_IDLE; m_frames = 0; m_bounces = 0; m_since = 0;
    m_top = 0; m_bot = 0; m_sign = 1'b0;
    e_move = 0; e_rst = 0; e_go = 0; e_win = 0;
  endtask

  task automatic enter_serve();
    m_state = P_SERVE; m_frames = 0; m_bounces = 0; e_rst = 1;
  endtask

  // One clock of game rules applied to the inputs seen at the edge
  task automatic model_step(input bit fb, input bit sb, input logic [5:0] y, input logic [2:0] dy);
    int div;
    e_move = 0;
    e_rst  = 0;
    case (m_state)
      P_IDLE, P_OVER: begin
        if (sb) begin
          m_top = 0; m_bot = 0; e_go = 0; e_win = 0;
          enter_serve();
        end
      end
      P_SERVE: begin
        if (fb) begin
          m_frames++;
          if (m_frames == SERVE_FRAMES) begin
            m_state = P_PLAY; m_sign = dy[2]; m_since = 0;
          end
        end
      end
      P_PLAY: begin
        div = START_DIV - m_bounces / RALLY_STEP;
        if (div < MIN_DIV) div = MIN_DIV;
        if (int'(y) >= GOAL_BOT) begin
          if (m_top < 15) m_top++;
          m_state = P_POINT; m_frames = 0;
        end else if (int'(y) <= GOAL_TOP) begin
          if (m_bot < 15) m_bot++;
          m_state = P_POINT; m_frames = 0;
        end else if (fb) begin
          m_since++;
          if (m_since >= div) begin
            e_move = 1; m_since = 0;
          end
        end
        if (dy[2] != m_sign) begin
          m_sign = dy[2]; m_bounces++;
        end
      end
      P_POINT: begin
        if (fb) begin
          m_frames++;
          if (m_frames == POINT_FRAMES) begin
            if (m_top == WIN_SCORE || m_bot == WIN_SCORE) begin
              m_state = P_OVER; e_go = 1; e_win = (m_top == WIN_SCORE) ? 1 : 0;
            end else begin
              enter_serve();
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [2:0] mk_dy(input bit s);
    logic [2:0] d;
    d = 3'($urandom);
    d[2] = s;
    return d;
  endfunction

  function automatic logic [5:0] mid_y();
    return 6'($urandom_range(GOAL_TOP + 1, GOAL_BOT - 1));
  endfunction

  task automatic cyc(input bit fb, input bit sb, input logic [5:0] y, input logic [2:0] dy);
    frame_tick = fb; start_btn = sb; ballY = y; ball_dy = dy;
    @(posedge clk); #1;
    model_step(fb, sb, y, dy);
    obs_moves += int'(move_tick);
    check_all();
    frame_tick = 1'b0; start_btn = 1'b0;
  endtask

  // n frame ticks with short random gaps; no bounces while in play
  task automatic frames(input int n);
    bit s;
    for (int i = 0; i < n; i++) begin
      s = (m_state == P_PLAY) ? m_sign : 1'($urandom_range(0, 1));
      cyc(1'b1, 1'b0, mid_y(), mk_dy(s));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        s = (m_state == P_PLAY) ? m_sign : s;
        cyc(1'b0, 1'b0, mid_y(), mk_dy(s));
      end
    end
  endtask

  task automatic toggles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, mid_y(), mk_dy(~m_sign));
  endtask

  task automatic goal(input bit top_scores);
    logic [5:0] y;
    y = top_scores ? 6'(GOAL_BOT + int'($urandom_range(0, 1))) : 6'($urandom_range(0, GOAL_TOP));
    cyc(1'b0, 1'b0, y, mk_dy(m_sign));
  endtask

  task automatic serve_out();
    for (int g = 0; g < 200 && m_state == P_SERVE; g++) frames(1);
  endtask

  task automatic point_out();
    for (int g = 0; g < 200 && m_state == P_POINT; g++) frames(1);
  endtask

  task automatic rally(input bit top_scores, input int nb);
    serve_out();
    frames(int'($urandom_range(0, 5)));
    toggles(nb);
    frames(int'($urandom_range(0, 5)));
    goal(top_scores);
    point_out();
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, mid_y(), mk_dy(1'b0));
    cyc(1'b1, 1'b0, mid_y(), mk_dy(1'b1));
    chk("idle_state", 32'(state), 32'(P_IDLE));

    // Start: one-cycle ball_rst, 30 serve frames, then play
    cyc(1'b0, 1'b1, mid_y(), mk_dy(1'b0));
    chk("t1_ball_rst", 32'(ball_rst), 32'd1);
    chk("t1_serve", 32'(state), 32'(P_SERVE));
    frames(SERVE_FRAMES - 1);
    chk("t1_serve29", 32'(state), 32'(P_SERVE));
    frames(1);
    chk("t1_play", 32'(state), 32'(P_PLAY));

    // No bounces: move on every 4th frame
    obs_moves = 0;
    frames(20);
    chk("t2_moves", 32'(obs_moves), 32'd5);

    // Eight bounces -> divider 2; twelve more -> saturates at 1
    toggles(8);
    obs_moves = 0;
    frames(10);
    chk("t3_div2", 32'(obs_moves), 32'd5);
    toggles(12);
    obs_moves = 0;
    frames(6);
    chk("t3_div1", 32'(obs_moves), 32'd6);

    // Goal coincident with a move frame
    cyc(1'b1, 1'b0, 6'd62, mk_dy(m_sign));
    chk("t4_no_move", 32'(move_tick), 32'd0);
    chk("t4_score_top", 32'(score_top), 32'd1);
    chk("t4_point", 32'(state), 32'(P_POINT));
    frames(POINT_FRAMES - 1);
    chk("t4_point44", 32'(state), 32'(P_POINT));
    cyc(1'b1, 1'b0, mid_y(), mk_dy(1'b0));
    chk("t4_reserve", 32'(state), 32'(P_SERVE));
    chk("t4_ball_rst", 32'(ball_rst), 32'd1);
    serve_out();
    obs_moves = 0;
    frames(8);
    chk("t4_div_reload", 32'(obs_moves), 32'd2);

    // Bottom player to WIN_SCORE
    goal(1'b0);
    point_out();
    for (int g = 0; g < 20 && m_state != P_OVER; g++) rally(1'b0, int'($urandom_range(0, 9)));
    chk("t5_over", 32'(state), 32'(P_OVER));
    chk("t5_game_over", 32'(game_over), 32'd1);
    chk("t5_winner", 32'(winner_top), 32'd0);
    chk("t5_score_bot", 32'(score_bot), 32'(WIN_SCORE));
    frames(3);
    cyc(1'b0, 1'b1, mid_y(), mk_dy(1'b0));
    chk("t5_restart", 32'(state), 32'(P_SERVE));
    chk("t5_clear_top", 32'(score_top), 32'd0);
    chk("t5_clear_bot", 32'(score_bot), 32'd0);

    // 3-2 with divider at 2, then asynchronous reset mid-cycle
    rally(1'b1, 2); rally(1'b0, 3); rally(1'b1, 1); rally(1'b0, 0); rally(1'b1, 5);
    serve_out();
    frames(2);
    toggles(8);
    frames(1);
    chk("t6_top3", 32'(score_top), 32'd3);
    chk("t6_bot2", 32'(score_bot), 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_async_state", 32'(state), 32'(P_IDLE));
    chk("t6_async_move", 32'(move_tick), 32'd0);
    chk("t6_async_rst", 32'(ball_rst), 32'd0);
    chk("t6_async_top", 32'(score_top), 32'd0);
    chk("t6_async_bot", 32'(score_bot), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all();
    cyc(1'b0, 1'b1, mid_y(), mk_dy(1'b0));
    serve_out();
    obs_moves = 0;
    frames(8);
    chk("t6_div_reset", 32'(obs_moves), 32'd2);

    // Random play against the model
    for (int i = 0; i < 4000; i++) begin
      bit         fb, sb, s;
      logic [5:0] y;
      fb = ($urandom_range(0, 2) == 0);
      sb = ($urandom_range(0, 60) == 0);
      y  = ($urandom_range(0, 40) == 0) ? 6'($urandom) : mid_y();
      s  = ($urandom_range(0, 7) == 0) ? ~m_sign : m_sign;
      cyc(fb, sb, y, mk_dy(s));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
